revram: RTL and testbench
=========================

// Module: revram
// PURPOSE
//  Block-order reverser (LIFO per block) on a ping-pong dual-port RAM (dpram) with two banks.
//  - Write side accepts a stream of DEPTH-word blocks into one bank.
//  - Read side drains the other bank last-word-first. Counterpart of the shiftram delay line:
//    the read pointer runs opposite to the write pointer.
//  - Sits between a stream producer and any stage needing time-reversed blocks
//    (FIR back-pass, bit-reversal prep).
// PARAMETERS
//  DWIDTH  16   data width, bits
//  DEPTH   256  words per block (>=2); AWIDTH=$clog2(DEPTH); RAM holds 2*DEPTH words
// PORTS
//  clk      in   1          single clock, all logic rising-edge
//  rst      in   1          asynchronous, active-low reset
//  s_valid  in   1          input word valid
//  s_ready  out  1          input word accepted when s_valid&s_ready
//  s_data   in   DWIDTH     input word
//  s_last   in   1          end of short block (only with REVRAM_LAST_EN)
//  m_valid  out  1          output word valid
//  m_ready  in   1          output word consumed when m_valid&m_ready
//  m_data   out  DWIDTH     output word
//  m_last   out  1          marks first-written word of block (last read out)
//  full     out  2          per-bank full flags, status only
// BEHAVIOUR
//  - Reset (rst=0): wbank=0, rbank=0, wcnt=0, full=2'b00, read FSM=IDLE.
//    Outputs s_ready=1, m_valid=0, m_last=0, m_data=0. Reset mid-block discards all RAM contents.
//  - Write side:
//    - Writes go to address {wbank,wcnt} on each accept; wcnt counts up.
//    - s_ready = ~full[wbank].
//    - On accept with wcnt==DEPTH-1: set full[wbank], store len[wbank]=DEPTH, toggle wbank, wcnt=0.
//  - Read FSM:
//    - IDLE: when full[rbank]=1, load rcnt=len[rbank]-1, issue RAM read -> PRIME.
//    - PRIME: RAM data (1-cycle latency) into output reg; m_valid=1 -> STREAM.
//    - STREAM: on m_valid&m_ready:
//      - rcnt>0: decrement, read next; output reg reloads with no bubble (prefetch + skid reg).
//      - last word: clear full[rbank], toggle rbank -> IDLE (or straight to PRIME if other bank full).
//    - m_last=1 exactly when the word from address {rbank,0} is presented.
//  - Latency: m_valid rises 2 clk after the edge that accepted the block's last word (banks empty).
//  - Throughput: 1 word/clk both sides sustained; back-to-back blocks without idle cycles.
//  - m_ready=0: m_data/m_last held stable while m_valid=1; no word lost or repeated.
//  - Both banks full: s_ready=0 until reader releases a bank.
//    Release and new fill may occur in the same cycle (different banks, no conflict).
//  - Same-cycle write to {wbank,x} and read of {rbank,y}: always different banks, never same address.
//  - s_valid with s_ready=0: data ignored, wcnt unchanged.
// CONFIGURATION
//  REVRAM_LAST_EN defined:
//    - s_last port present.
//    - Accept with s_last=1 closes block early: len[wbank]=wcnt+1, same bank swap as full block.
//    - Accept at wcnt==DEPTH-1 closes block regardless of s_last.
//    - One-word block (s_last on first word) yields one output with m_last=1.
//  REVRAM_LAST_EN undefined:
//    - s_last port absent.
//    - len fixed at DEPTH; no length storage.
// TESTING
//  1. DEPTH=8, push 0..7 with m_ready=1 -> out 7,6,..,0; m_last only on 0.
//     m_valid rises 2 clk after accepting 7.
//  2. Push 3 blocks back-to-back (0..23), m_ready=1 -> 7..0,15..8,23..16; no gaps after first word.
//  3. m_ready=0 after 2 outputs for 5 clk -> m_data held; s_ready drops once second bank fills;
//     stream resumes intact.
//  4. Random s_valid/m_ready at 50% over 1000 blocks -> scoreboard matches per-block reversal,
//     no loss or duplicate.
//  5. Assert rst low mid-read of bank 0 with bank 1 full -> next clk m_valid=0, full=00,
//     s_ready=1; new block 100..107 outputs 107..100.
//  6. REVRAM_LAST_EN: s_last on 3rd word of 10,11,12 -> outputs 12,11,10, m_last on 10;
//     next block starts at wcnt=0.

Source files
------------

// File: rtl/revram.sv
// Block-order reverser: ping-pong two-bank RAM, blocks written in order, read back last-word-first.
// Optional REVRAM_LAST_EN adds s_last so a block can be closed before DEPTH words.
module revram #(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DWIDTH-1:0] s_data,
`ifdef REVRAM_LAST_EN
  input  logic              s_last,
`endif
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_last,
  output logic [1:0]        full
);

  localparam int unsigned AWIDTH    = $clog2(DEPTH);
  localparam int unsigned RAM_WORDS = 2 ** (AWIDTH + 1);
  localparam logic [AWIDTH-1:0] CNT_MAX = AWIDTH'(DEPTH - 1);

  typedef enum logic {IDLE, STREAM} rd_state_t;

  rd_state_t         state, state_next;
  logic              wbank, rbank, rel_bank;
  logic [AWIDTH-1:0] wcnt, rcnt, raddr_lo, blk_lenm1;
  logic [1:0]        pend;
  logic              accept, close, issue, issue_end, room, pop, release_blk;
  logic [1:0]        occ;
  logic              rvld, rlast;
  logic [DWIDTH-1:0] rdata;
  logic              skid_vld, skid_last;
  logic [DWIDTH-1:0] skid_data;
  logic [DWIDTH-1:0] mem [RAM_WORDS];

  // ---------------- write side ----------------
  assign s_ready = ~full[wbank];
  assign accept  = s_valid & s_ready;
`ifdef REVRAM_LAST_EN
  logic [AWIDTH-1:0] lenm1 [2];

  assign close     = accept & (s_last | (wcnt == CNT_MAX));
  assign blk_lenm1 = lenm1[rbank];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lenm1[0] <= '0;
      lenm1[1] <= '0;
    end else if (close) begin
      lenm1[wbank] <= wcnt;
    end
  end
`else
  assign close     = accept & (wcnt == CNT_MAX);
  assign blk_lenm1 = CNT_MAX;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wbank <= 1'b0;
      wcnt  <= '0;
    end else if (accept) begin
      if (close) begin
        wbank <= ~wbank;
        wcnt  <= '0;
      end else begin
        wcnt <= wcnt + AWIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[{wbank, wcnt}] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (issue) rdata <= mem[{rbank, raddr_lo}];
  end

  // A bank stays full until its last word leaves the output register, even
  // though its reads finish earlier; pend stops the reader re-issuing it.
  assign pop         = m_valid & m_ready;
  assign release_blk = pop & m_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full     <= '0;
      pend     <= '0;
      rel_bank <= 1'b0;
    end else begin
      if (close)     full[wbank] <= 1'b1;
      if (issue_end) pend[rbank] <= 1'b1;
      if (release_blk) begin
        full[rel_bank] <= 1'b0;
        pend[rel_bank] <= 1'b0;
        rel_bank       <= ~rel_bank;
      end
    end
  end

  // ---------------- read FSM ----------------
  assign occ  = {1'b0, m_valid} + {1'b0, skid_vld} + {1'b0, rvld};
  assign room = (occ < 2'd2) | ((occ == 2'd2) & pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:   if (issue && !issue_end) state_next = STREAM;
      STREAM: if (issue_end) state_next = IDLE;
    endcase
  end

  always_comb begin
    raddr_lo  = rcnt;
    issue     = 1'b0;
    issue_end = 1'b0;
    unique case (state)
      IDLE: begin
        raddr_lo  = blk_lenm1;
        issue     = room & full[rbank] & ~pend[rbank];
        issue_end = issue & (blk_lenm1 == '0);
      end
      STREAM: begin
        issue     = room;
        issue_end = issue & (rcnt == '0);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rbank <= 1'b0;
      rcnt  <= '0;
      rvld  <= 1'b0;
      rlast <= 1'b0;
    end else begin
      rvld  <= issue;
      rlast <= issue & (raddr_lo == '0);
      if (issue) begin
        if (issue_end) rbank <= ~rbank;
        else           rcnt  <= raddr_lo - AWIDTH'(1);
      end
    end
  end

  // ---------------- output register + skid ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_last    <= 1'b0;
      skid_vld  <= 1'b0;
      skid_data <= '0;
      skid_last <= 1'b0;
    end else if (pop) begin
      if (skid_vld) begin
        m_data   <= skid_data;
        m_last   <= skid_last;
        skid_vld <= 1'b0;
      end else if (rvld) begin
        m_data <= rdata;
        m_last <= rlast;
      end else begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
    end else if (rvld) begin
      if (m_valid) begin
        skid_vld  <= 1'b1;
        skid_data <= rdata;
        skid_last <= rlast;
      end else begin
        m_valid <= 1'b1;
        m_data  <= rdata;
        m_last  <= rlast;
      end
    end
  end

endmodule

// File: tb/tb_revram.sv
// Self-checking bench for revram: directed scenarios plus randomized traffic
// against a queue model of per-block reversal and bank occupancy.
module tb_revram;

  localparam int unsigned DW = 16;
  localparam int unsigned DP = 8;
`ifdef REVRAM_LAST_EN
  localparam bit LAST_EN = 1'b1;
`else
  localparam bit LAST_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, s_valid, s_ready, s_last, m_valid, m_ready, m_last;
  logic [DW-1:0] s_data, m_data;
  logic [1:0]    full;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } ent_t;

  logic [DW-1:0] cur[$];
  ent_t          expq[$];
  int unsigned   tests = 0, fails = 0;
  int unsigned   closed_blk = 0, released_blk = 0, npop = 0;
  int unsigned   start, gaps, base_blk;
  bit            last_acc, seen;

  always #5 clk = ~clk;

  revram #(.DWIDTH(DW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
`ifdef REVRAM_LAST_EN
    .s_last(s_last),
`endif
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .full(full)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: evaluate the handshakes that the coming edge will complete.
  task automatic tick();
    ent_t e;
    @(negedge clk);
    last_acc = 1'b0;
    if (rst) begin
      chk("s_ready", s_ready, 32'((closed_blk - released_blk) < 2));
      if (s_valid && s_ready) begin
        last_acc = 1'b1;
        cur.push_back(s_data);
        if ((LAST_EN && s_last) || cur.size() == DP) begin
          for (int i = int'(cur.size()) - 1; i >= 0; i--)
            expq.push_back('{d: cur[i], l: (i == 0)});
          cur.delete();
          closed_blk++;
        end
      end
      if (m_valid && m_ready) begin
        if (expq.size() == 0) begin
          chk("out_word_expected", m_valid, 0);
        end else begin
          e = expq.pop_front();
          chk("m_data", m_data, e.d);
          chk("m_last", m_last, e.l);
          if (e.l) released_blk++;
        end
        npop++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int unsigned base, input int unsigned n,
                      input int unsigned last_at, input logic rdy);
    int unsigned k = 0;
    m_ready = rdy;
    for (int c = 0; c < 400 && k < n; c++) begin
      s_valid = 1'b1;
      s_data  = DW'(base + k);
      s_last  = (k == last_at);
      tick();
      if (last_acc) k++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("feed_done", k, n);
  endtask

  task automatic drain(input string tag);
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int n = 0; n < 200 && (expq.size() != 0 || m_valid); n++) tick();
    chk(tag, expq.size(), 0);
  endtask

  initial begin
    rst = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_full", full, 0);
    rst = 1'b1;
    tick();

    // Single block, latency of two clocks after the last accept
    feed(0, 8, 99, 1'b1);
    chk("t1_full", full, 2'b01);
    chk("t1_lat0", m_valid, 0);
    tick();
    chk("t1_lat1", m_valid, 0);
    tick();
    chk("t1_lat2", m_valid, 1);
    chk("t1_first", m_data, 7);
    chk("t1_first_last", m_last, 0);
    drain("t1_drain");

    // Three back-to-back blocks; first two must stream without gaps
    start = npop; gaps = 0; seen = 1'b0; m_ready = 1'b1;
    begin
      int unsigned k = 0;
      for (int n = 0; n < 300 && npop - start < 24; n++) begin
        s_valid = (k < 24);
        s_data  = DW'(k);
        if (m_valid) seen = 1'b1;
        else if (seen && npop - start < 16) gaps++;
        tick();
        if (last_acc) k++;
      end
    end
    s_valid = 1'b0;
    chk("t2_gaps", gaps, 0);
    chk("t2_count", npop - start, 24);
    drain("t2_drain");

    // Backpressure: stall after two outputs while the second bank fills
    start = npop; m_ready = 1'b1;
    begin
      int unsigned k = 0;
      for (int n = 0; n < 100 && npop - start < 2; n++) begin
        s_valid = (k < 16); s_data = DW'(32 + k);
        tick();
        if (last_acc) k++;
      end
      m_ready = 1'b0;
      for (int n = 0; n < 5; n++) begin
        s_valid = (k < 16); s_data = DW'(32 + k);
        chk("t3_hold_valid", m_valid, 1);
        chk("t3_hold_data", m_data, expq[0].d);
        tick();
        if (last_acc) k++;
      end
      chk("t3_sready_low", s_ready, 0);
      chk("t3_full", full, 2'b11);
      chk("t3_words_in", k, 16);
    end
    drain("t3_drain");
    chk("t3_count", npop - start, 16);

    // Random valid/ready over 1000 blocks
    base_blk = closed_blk;
    for (int n = 0; n < 60000 && closed_blk - base_blk < 1000; n++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data  = DW'($urandom);
      s_last  = LAST_EN && ($urandom_range(0, 7) == 0);
      m_ready = 1'($urandom_range(0, 1));
      tick();
    end
    s_last = 1'b0;
    chk("t4_blocks", closed_blk - base_blk, 1000);
    drain("t4_drain");

    // Reset while reading bank 0 with bank 1 full
    feed(0, 16, 99, 1'b0);
    chk("t5_full", full, 2'b11);
    start = npop; m_ready = 1'b1;
    for (int n = 0; n < 20 && npop - start < 2; n++) tick();
    chk("t5_popped", npop - start, 2);
    rst = 1'b0;
    #2;
    chk("t5_async_m_valid", m_valid, 0);
    chk("t5_async_full", full, 0);
    @(posedge clk);
    #1;
    chk("t5_m_valid", m_valid, 0);
    chk("t5_full0", full, 0);
    chk("t5_s_ready", s_ready, 1);
    chk("t5_m_last", m_last, 0);
    expq.delete(); cur.delete(); closed_blk = 0; released_blk = 0;
    rst = 1'b1;
    start = npop;
    feed(100, 8, 99, 1'b1);
    drain("t5_drain");
    chk("t5_count", npop - start, 8);

`ifdef REVRAM_LAST_EN
    // Short blocks closed by s_last, then a full block from wcnt=0
    start = npop;
    feed(10, 3, 2, 1'b1);
    drain("t6_short_drain");
    chk("t6_short_count", npop - start, 3);
    start = npop;
    feed(40, 1, 0, 1'b1);
    drain("t6_one_drain");
    chk("t6_one_count", npop - start, 1);
    start = npop;
    feed(20, 8, 99, 1'b1);
    drain("t6_full_drain");
    chk("t6_full_count", npop - start, 8);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
